// File: rtl/guess_pkg.sv
// Shared definitions for the 1A2B guess datapath.
//   state_e     : scan controller states
//   DIGITS_DEF  : default number of digits per secret/guess
//   DIGIT_W_DEF : default bits per BCD digit
//   BCD_MAX     : largest legal digit value in a guess
package guess_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StResult
  } state_e;

  localparam int unsigned DIGITS_DEF  = 4;
  localparam int unsigned DIGIT_W_DEF = 4;
  localparam int unsigned BCD_MAX     = 9;

  // Width of an index able to address every digit; never zero.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/guess_datapath_if.sv
// FSM <-> guess datapath interface.
//   master : FSM side (drives clear/save_test/enter/digit_in, reads scores)
//   slave  : datapath side
// Optional ATTEMPT_COUNT_EN adds the 8-bit attempts counter output.
interface guess_datapath_if
  import guess_pkg::*;
#(
  parameter int unsigned DIGITS  = DIGITS_DEF,
  parameter int unsigned DIGIT_W = DIGIT_W_DEF,
  parameter int unsigned CNT_W   = 3
);

  logic                        clear;
  logic                        save_test;
  logic                        enter;
  logic [DIGITS*DIGIT_W-1:0]   digit_in;
  logic                        busy;
  logic                        done;
  logic [CNT_W-1:0]            a_count;
  logic [CNT_W-1:0]            b_count;
  logic                        dp_same;
  logic                        dp_input_error;
`ifdef ATTEMPT_COUNT_EN
  logic [7:0]                  attempts;
`endif

`ifdef ATTEMPT_COUNT_EN
  modport master (
    output clear, save_test, enter, digit_in,
    input  busy, done, a_count, b_count, dp_same, dp_input_error, attempts
  );
  modport slave (
    input  clear, save_test, enter, digit_in,
    output busy, done, a_count, b_count, dp_same, dp_input_error, attempts
  );
`else
  modport master (
    output clear, save_test, enter, digit_in,
    input  busy, done, a_count, b_count, dp_same, dp_input_error
  );
  modport slave (
    input  clear, save_test, enter, digit_in,
    output busy, done, a_count, b_count, dp_same, dp_input_error
  );
`endif

endinterface

// File: rtl/guess_datapath_digit_mux.sv
// digit_mux: combinational selector of one digit from a packed digit bus.
//   bus_i   : DIGITS packed digits, digit 0 in the LSBs
//   sel_i   : index of the digit to select
//   digit_o : selected digit (zero for an out-of-range index)
module digit_mux #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [DIGITS*DIGIT_W-1:0] bus_i,
  input  logic [IDX_W-1:0]          sel_i,
  output logic [DIGIT_W-1:0]        digit_o
);

  always_comb begin
    digit_o = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sel_i == IDX_W'(k)) digit_o = bus_i[k*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: rtl/guess_datapath.sv
// guess_datapath: stores the 1A2B secret and scores a guess one digit pair per cycle.
//   clka     : system clock, all state on posedge
//   reset_n  : synchronous active-low reset
//   bus      : guess_datapath_if slave port
//              in : clear, save_test, enter, digit_in
//              out: busy, done, a_count, b_count, dp_same, dp_input_error
//              (+ attempts when ATTEMPT_COUNT_EN is defined)
// A scan walks all DIGITS*DIGITS (i,j) pairs, j fastest, then spends one RESULT
// cycle publishing the scores; done is registered so it rises DIGITS*DIGITS+1
// edges after the edge that accepted enter.
module guess_datapath
  import guess_pkg::*;
#(
  parameter int unsigned DIGITS  = DIGITS_DEF,
  parameter int unsigned DIGIT_W = DIGIT_W_DEF,
  parameter int unsigned CNT_W   = 3
) (
  input logic      clka,
  input logic      reset_n,
  guess_datapath_if.slave bus
);

  localparam int unsigned IdxW = idx_width(DIGITS);
  localparam int unsigned BusW = DIGITS * DIGIT_W;
  localparam logic [IdxW-1:0]    LastIdx = IdxW'(DIGITS - 1);
  localparam logic [CNT_W-1:0]   AllHit  = CNT_W'(DIGITS);
  localparam logic [DIGIT_W-1:0] DigMax  = DIGIT_W'(BCD_MAX);

  state_e            state_q, state_d;
  logic [BusW-1:0]   secret_q, secret_d;
  logic              secret_valid_q, secret_valid_d;
  logic [BusW-1:0]   guess_q, guess_d;
  logic [IdxW-1:0]   i_q, i_d;
  logic [IdxW-1:0]   j_q, j_d;
  logic [CNT_W-1:0]  a_q, a_d;
  logic [CNT_W-1:0]  b_q, b_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  a_count_q, a_count_d;
  logic [CNT_W-1:0]  b_count_q, b_count_d;
  logic              same_q, same_d;
  logic              in_err_q, in_err_d;
  logic              done_q, done_d;
`ifdef ATTEMPT_COUNT_EN
  logic [7:0]        attempts_q, attempts_d;
`endif

  logic [DIGIT_W-1:0] s_i, g_i, g_j;

  digit_mux #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .IDX_W   (IdxW)
  ) u_mux_si (
    .bus_i   (secret_q),
    .sel_i   (i_q),
    .digit_o (s_i)
  );

  digit_mux #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .IDX_W   (IdxW)
  ) u_mux_gi (
    .bus_i   (guess_q),
    .sel_i   (i_q),
    .digit_o (g_i)
  );

  digit_mux #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .IDX_W   (IdxW)
  ) u_mux_gj (
    .bus_i   (guess_q),
    .sel_i   (j_q),
    .digit_o (g_j)
  );

  always_comb begin
    state_d        = state_q;
    secret_d       = secret_q;
    secret_valid_d = secret_valid_q;
    guess_d        = guess_q;
    i_d            = i_q;
    j_d            = j_q;
    a_d            = a_q;
    b_d            = b_q;
    err_d          = err_q;
    a_count_d      = a_count_q;
    b_count_d      = b_count_q;
    same_d         = same_q;
    in_err_d       = in_err_q;
    done_d         = 1'b0;
`ifdef ATTEMPT_COUNT_EN
    attempts_d     = attempts_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.save_test) begin
          secret_d       = bus.digit_in;
          secret_valid_d = 1'b1;
`ifdef ATTEMPT_COUNT_EN
          attempts_d     = '0;
`endif
        end
        // A same-cycle save_test makes the secret valid for this enter too.
        if (bus.enter && (secret_valid_q || bus.save_test)) begin
          guess_d = bus.digit_in;
          i_d     = '0;
          j_d     = '0;
          a_d     = '0;
          b_d     = '0;
          err_d   = 1'b0;
          state_d = StScan;
        end
      end

      StScan: begin
        if ((i_q == j_q) && (s_i == g_i)) a_d = a_q + CNT_W'(1);
        if ((i_q != j_q) && (s_i == g_j)) b_d = b_q + CNT_W'(1);
        if (((i_q < j_q) && (g_i == g_j)) || (g_j > DigMax)) err_d = 1'b1;

        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            i_d     = '0;
            state_d = StResult;
          end else begin
            i_d = i_q + IdxW'(1);
          end
        end else begin
          j_d = j_q + IdxW'(1);
        end
      end

      StResult: begin
        a_count_d = a_q;
        b_count_d = b_q;
        in_err_d  = err_q;
        same_d    = (a_q == AllHit) && !err_q;
        done_d    = 1'b1;
        state_d   = StIdle;
`ifdef ATTEMPT_COUNT_EN
        if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  // clear behaves exactly like reset, aborting any scan in flight.
  always_ff @(posedge clka) begin
    if (!reset_n || bus.clear) begin
      state_q        <= StIdle;
      secret_q       <= '0;
      secret_valid_q <= 1'b0;
      guess_q        <= '0;
      i_q            <= '0;
      j_q            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      err_q          <= 1'b0;
      a_count_q      <= '0;
      b_count_q      <= '0;
      same_q         <= 1'b0;
      in_err_q       <= 1'b0;
      done_q         <= 1'b0;
`ifdef ATTEMPT_COUNT_EN
      attempts_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      secret_valid_q <= secret_valid_d;
      guess_q        <= guess_d;
      i_q            <= i_d;
      j_q            <= j_d;
      a_q            <= a_d;
      b_q            <= b_d;
      err_q          <= err_d;
      a_count_q      <= a_count_d;
      b_count_q      <= b_count_d;
      same_q         <= same_d;
      in_err_q       <= in_err_d;
      done_q         <= done_d;
`ifdef ATTEMPT_COUNT_EN
      attempts_q     <= attempts_d;
`endif
    end
  end

  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_q;
  assign bus.a_count        = a_count_q;
  assign bus.b_count        = b_count_q;
  assign bus.dp_same        = same_q;
  assign bus.dp_input_error = in_err_q;
`ifdef ATTEMPT_COUNT_EN
  assign bus.attempts       = attempts_q;
`endif

endmodule

// File: tb/tb_guess_datapath.sv
// Testbench for guess_datapath: directed 1A2B cases plus randomized secrets and
// guesses scored against a digit-counting reference model.
module tb_guess_datapath;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  guess_datapath_if #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .CNT_W   (CNT_W)
  ) dp_if ();

  guess_datapath #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clka    (clk),
    .reset_n (reset_n),
    .bus     (dp_if)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [15:0] secret_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: A = same digit same place, B = same digit other place,
  // error = any guess digit above 9 or any digit appearing twice.
  function automatic void model(input logic [15:0] s, input logic [15:0] g,
                                output int a, output int b, output bit err);
    logic [3:0] sd[4];
    logic [3:0] gd[4];
    a = 0; b = 0; err = 0;
    for (int k = 0; k < 4; k++) begin
      sd[k] = s[4*k +: 4];
      gd[k] = g[4*k +: 4];
    end
    for (int x = 0; x < 4; x++) begin
      if (gd[x] > 4'd9) err = 1;
      for (int y = 0; y < 4; y++) begin
        if (sd[x] == gd[y]) begin
          if (x == y) a++;
          else b++;
        end
        if (x < y && gd[x] == gd[y]) err = 1;
      end
    end
  endfunction

  function automatic logic [15:0] rand_distinct_bcd();
    logic [3:0] d[10];
    logic [3:0] t;
    int r;
    for (int k = 0; k < 10; k++) d[k] = 4'(k);
    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(k, 9);
      t = d[k]; d[k] = d[r]; d[r] = t;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic save(input logic [15:0] v);
    @(negedge clk);
    dp_if.save_test = 1'b1;
    dp_if.digit_in  = v;
    @(negedge clk);
    dp_if.save_test = 1'b0;
    secret_m = v;
  endtask

  // Issue one guess (optionally with a same-cycle save_test) and check the result.
  task automatic score(input string tag, input logic [15:0] g, input bit with_save);
    int ea, eb, edges;
    bit eerr;
    logic [CNT_W-1:0] prev_a;
    prev_a = dp_if.a_count;
    @(negedge clk);
    dp_if.enter    = 1'b1;
    dp_if.digit_in = g;
    if (with_save) begin
      dp_if.save_test = 1'b1;
      secret_m = g;
    end
    model(secret_m, g, ea, eb, eerr);
    @(negedge clk);
    dp_if.enter     = 1'b0;
    dp_if.save_test = 1'b0;
    dp_if.digit_in  = 16'($urandom);
    check({tag, ".busy"}, 32'(dp_if.busy), 32'd1);
    edges = 0;
    while (dp_if.done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (edges == 8) check({tag, ".hold"}, 32'(dp_if.a_count), 32'(prev_a));
    end
    check({tag, ".latency"}, 32'(edges), 32'd17);
    check({tag, ".a"}, 32'(dp_if.a_count), 32'(ea));
    check({tag, ".b"}, 32'(dp_if.b_count), 32'(eb));
    check({tag, ".err"}, 32'(dp_if.dp_input_error), 32'(eerr));
    check({tag, ".same"}, 32'(dp_if.dp_same), 32'(ea == 4 && !eerr));
    check({tag, ".busy_end"}, 32'(dp_if.busy), 32'd0);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(dp_if.done), 32'd0);
    check({tag, ".held"}, 32'(dp_if.a_count), 32'(ea));
  endtask

  task automatic idle_enter(input string tag);
    bit saw_busy, saw_done;
    saw_busy = 0; saw_done = 0;
    @(negedge clk);
    dp_if.enter    = 1'b1;
    dp_if.digit_in = 16'h1234;
    @(negedge clk);
    dp_if.enter = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dp_if.busy === 1'b1) saw_busy = 1;
      if (dp_if.done === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    check({tag, ".no_busy"}, 32'(saw_busy), 32'd0);
    check({tag, ".no_done"}, 32'(saw_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dones, ea, eb;
    bit eerr;
    logic [15:0] g;

    dp_if.clear     = 1'b0;
    dp_if.save_test = 1'b0;
    dp_if.enter     = 1'b0;
    dp_if.digit_in  = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(dp_if.busy), 32'd0);
    check("rst.done", 32'(dp_if.done), 32'd0);
    check("rst.a", 32'(dp_if.a_count), 32'd0);
    check("rst.b", 32'(dp_if.b_count), 32'd0);
    check("rst.same", 32'(dp_if.dp_same), 32'd0);
    check("rst.err", 32'(dp_if.dp_input_error), 32'd0);
`ifdef ATTEMPT_COUNT_EN
    check("rst.attempts", 32'(dp_if.attempts), 32'd0);
`endif
    reset_n = 1'b1;

    idle_enter("nosecret");

    save(16'h1234);
    score("g1234", 16'h1234, 0);
    check("g1234.a4", 32'(dp_if.a_count), 32'd4);
    check("g1234.same1", 32'(dp_if.dp_same), 32'd1);
    score("g4321", 16'h4321, 0);
    check("g4321.b4", 32'(dp_if.b_count), 32'd4);
    score("g1243", 16'h1243, 0);
    check("g1243.a2", 32'(dp_if.a_count), 32'd2);
    check("g1243.b2", 32'(dp_if.b_count), 32'd2);
    score("g5678", 16'h5678, 0);
    check("g5678.a0", 32'(dp_if.a_count), 32'd0);
    score("g1123", 16'h1123, 0);
    check("g1123.err1", 32'(dp_if.dp_input_error), 32'd1);
    check("g1123.same0", 32'(dp_if.dp_same), 32'd0);
    score("g12A4", 16'h12A4, 0);
    check("g12A4.err1", 32'(dp_if.dp_input_error), 32'd1);

    // enter and save_test pulsed mid-scan must be ignored.
    @(negedge clk);
    dp_if.enter    = 1'b1;
    dp_if.digit_in = 16'h1234;
    @(negedge clk);
    dp_if.enter = 1'b0;
    repeat (5) @(negedge clk);
    dp_if.enter     = 1'b1;
    dp_if.save_test = 1'b1;
    dp_if.digit_in  = 16'h5678;
    @(negedge clk);
    dp_if.enter     = 1'b0;
    dp_if.save_test = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (dp_if.done === 1'b1) dones++;
      @(negedge clk);
    end
    check("midscan.dones", 32'(dones), 32'd1);
    check("midscan.a", 32'(dp_if.a_count), 32'd4);
    score("after_mid", 16'h1234, 0);

    score("save_enter", 16'h9876, 1);
    check("save_enter.a4", 32'(dp_if.a_count), 32'd4);

    for (int n = 0; n < 24; n++) begin
      if (n % 6 == 0) save(rand_distinct_bcd());
      case ($urandom_range(0, 2))
        0: g = 16'($urandom);
        1: g = rand_distinct_bcd();
        default: g = {secret_m[11:0], secret_m[15:12]};
      endcase
      score("rand", g, 0);
    end

    // clear during the scan: abort, zero everything, forget the secret.
    save(16'h1234);
    score("pre_clear", 16'h1234, 0);
    @(negedge clk);
    dp_if.enter    = 1'b1;
    dp_if.digit_in = 16'h1234;
    @(negedge clk);
    dp_if.enter = 1'b0;
    repeat (5) @(negedge clk);
    dp_if.clear = 1'b1;
    @(negedge clk);
    dp_if.clear = 1'b0;
    check("clear.busy", 32'(dp_if.busy), 32'd0);
    check("clear.done", 32'(dp_if.done), 32'd0);
    check("clear.a", 32'(dp_if.a_count), 32'd0);
    check("clear.b", 32'(dp_if.b_count), 32'd0);
    check("clear.same", 32'(dp_if.dp_same), 32'd0);
    check("clear.err", 32'(dp_if.dp_input_error), 32'd0);
    idle_enter("clear.invalid");

`ifdef ATTEMPT_COUNT_EN
    check("att.clear", 32'(dp_if.attempts), 32'd0);
    save(16'h1234);
    score("att1", 16'h5678, 0);
    score("att2", 16'h4321, 0);
    score("att3", 16'h1234, 0);
    check("att.three", 32'(dp_if.attempts), 32'd3);
    save(16'h2468);
    check("att.save", 32'(dp_if.attempts), 32'd0);
`endif

    model(16'h1234, 16'h1243, ea, eb, eerr);
    check("model.sanity", 32'(ea * 10 + eb), 32'd22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
